tick_timer_bank: RTL

//  Bank of NCH independent down-counting tick timers for the floppy CPU.
//  All channels share one prescaler that divides MCLKFREQ down to TICKHZ.

---
 rtl/tick_timer_pkg.sv | 17 +
 rtl/tick_timer_bank_if.sv | 16 +
 rtl/tick_timer_chan.sv | 90 +++++++++
 rtl/tick_timer_bank.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/tick_timer_pkg.sv
// Shared constants for the tick timer bank: register offsets and CTRL bit layout.
// Optional feature macro: TICK_TIMER_IRQ_EN (adds the irq output).
package tick_timer_pkg;

  localparam int unsigned REG_W  = 2;
  localparam int unsigned CTRL_W = 3;

  localparam logic [REG_W-1:0] REG_COUNT  = 2'd0;
  localparam logic [REG_W-1:0] REG_CTRL   = 2'd1;
  localparam logic [REG_W-1:0] REG_STATUS = 2'd2;
  localparam logic [REG_W-1:0] REG_TICK   = 2'd3;

  localparam int unsigned CTRL_EN = 0;
  localparam int unsigned CTRL_AR = 1;
  localparam int unsigned CTRL_IE = 2;

endpackage

// File: rtl/tick_timer_bank_if.sv
// Register-file access bus of the tick timer bank: address, write data, strobes, read data.
interface tick_timer_bank_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned AW = $clog2(NCH) + 2;

  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] di;
  logic             wren;
  logic             rden;
  logic [WIDTH-1:0] q;

  modport master (output addr, output di, output wren, output rden, input q);
  modport slave  (input addr, input di, input wren, input rden, output q);
endinterface

// File: rtl/tick_timer_chan.sv
// One down-counting tick timer channel: count, reload, ctrl and sticky expiry flag.
// Optional feature macro: TICK_TIMER_IRQ_EN (adds the irq_c next-state request output).
module tick_timer_chan
  import tick_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              wr_count,
  input  logic              wr_ctrl,
  input  logic              wr_status,
  input  logic [WIDTH-1:0]  di,
  output logic [WIDTH-1:0]  count,
  output logic [CTRL_W-1:0] ctrl,
  output logic              expired
`ifdef TICK_TIMER_IRQ_EN
  ,
  output logic              irq_c
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  reload_q, reload_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              expired_q, expired_d;
  logic              expire_set;
  logic [0:0]        state_c;

  // Channel state is implied by enable and a non-zero count
  always_comb begin
    state_c = ST_IDLE;
    if (ctrl_q[CTRL_EN] && (count_q != '0)) state_c = ST_RUN;
  end

  // Next-state: register writes, tick decrement, reload and expiry
  always_comb begin
    count_d    = count_q;
    reload_d   = reload_q;
    ctrl_d     = ctrl_q;
    expired_d  = expired_q;
    expire_set = 1'b0;

    if (wr_count) begin
      count_d  = di;
      reload_d = di;
    end else if (tick && (state_c == ST_RUN)) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        expire_set = 1'b1;
        count_d    = ctrl_q[CTRL_AR] ? reload_q : '0;
      end
    end

    if (wr_ctrl) ctrl_d = di[CTRL_W-1:0];

    // Clear first so a same-cycle expiry still sets the flag
    if (wr_status && di[0]) expired_d = 1'b0;
    if (expire_set)         expired_d = 1'b1;
  end

  // Channel state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= '0;
      reload_q  <= '0;
      ctrl_q    <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      reload_q  <= reload_d;
      ctrl_q    <= ctrl_d;
      expired_q <= expired_d;
    end
  end

  assign count   = count_q;
  assign ctrl    = ctrl_q;
  assign expired = expired_q;

`ifdef TICK_TIMER_IRQ_EN
  assign irq_c = expired_d & ctrl_d[CTRL_IE];
`endif

endmodule

// File: rtl/tick_timer_bank.sv
// Bank of NCH tick timers sharing one prescaler, with a small register file.
// Optional feature macro: TICK_TIMER_IRQ_EN (adds registered irq = OR of expired & ie).
module tick_timer_bank
  import tick_timer_pkg::*;
#(
  parameter int unsigned MCLKFREQ = 24000000,
  parameter int unsigned TICKHZ   = 100,
  parameter int unsigned NCH      = 4,
  parameter int unsigned WIDTH    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  tick_timer_bank_if.slave bus,
  output logic             tick
`ifdef TICK_TIMER_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int unsigned PRESCALE = MCLKFREQ / TICKHZ;
  localparam int unsigned PW       = $clog2(PRESCALE);

  logic [PW-1:0]     presc_q, presc_d;
  logic              tick_q, tick_d;
  logic [WIDTH-1:0]  tick_cnt_q, tick_cnt_d;
  logic [WIDTH-1:0]  q_q, q_d;

  logic [3:0]        sel_chan;
  logic [REG_W-1:0]  sel_reg;

  logic [NCH-1:0]    wr_count, wr_ctrl, wr_status;
  logic [WIDTH-1:0]  ch_count [NCH];
  logic [CTRL_W-1:0] ch_ctrl  [NCH];
  logic [NCH-1:0]    ch_exp;

  assign sel_chan = 4'(bus.addr >> 2);
  assign sel_reg  = bus.addr[REG_W-1:0];

  // Shared prescaler and free-running tick counter
  always_comb begin
    presc_d    = presc_q - PW'(1);
    tick_d     = 1'b0;
    tick_cnt_d = tick_cnt_q;
    if (presc_q == '0) begin
      presc_d    = PW'(PRESCALE - 1);
      tick_d     = 1'b1;
      tick_cnt_d = tick_cnt_q + WIDTH'(1);
    end
  end

  // Write decode; out-of-range channels match nothing
  always_comb begin
    wr_count  = '0;
    wr_ctrl   = '0;
    wr_status = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (bus.wren && (sel_chan == 4'(i))) begin
        case (sel_reg)
          REG_COUNT:  wr_count[i]  = 1'b1;
          REG_CTRL:   wr_ctrl[i]   = 1'b1;
          REG_STATUS: wr_status[i] = 1'b1;
          default:    ;
        endcase
      end
    end
  end

  // Read mux; q holds between reads and out-of-range channels read 0
  always_comb begin
    q_d = q_q;
    if (bus.rden) begin
      q_d = '0;
      for (int i = 0; i < int'(NCH); i++) begin
        if (sel_chan == 4'(i)) begin
          case (sel_reg)
            REG_COUNT:  q_d = ch_count[i];
            REG_CTRL:   q_d = WIDTH'(ch_ctrl[i]);
            REG_STATUS: q_d = WIDTH'(ch_exp[i]);
            default:    q_d = tick_cnt_q;
          endcase
        end
      end
    end
  end

  // Top-level registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q    <= PW'(PRESCALE - 1);
      tick_q     <= 1'b0;
      tick_cnt_q <= '0;
      q_q        <= '0;
    end else begin
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      tick_cnt_q <= tick_cnt_d;
      q_q        <= q_d;
    end
  end

  assign tick  = tick_q;
  assign bus.q = q_q;

`ifdef TICK_TIMER_IRQ_EN
  logic [NCH-1:0] ch_irq;
  logic           irq_q, irq_d;

  // Interrupt request from any enabled expired channel
  always_comb begin
    irq_d = |ch_irq;
  end

  // Interrupt output register
  always_ff @(posedge clk) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

  for (genvar g = 0; g < int'(NCH); g++) begin : g_chan
    tick_timer_chan #(.WIDTH(WIDTH)) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick_q),
      .wr_count  (wr_count[g]),
      .wr_ctrl   (wr_ctrl[g]),
      .wr_status (wr_status[g]),
      .di        (bus.di),
      .count     (ch_count[g]),
      .ctrl      (ch_ctrl[g]),
      .expired   (ch_exp[g])
`ifdef TICK_TIMER_IRQ_EN
      ,
      .irq_c     (ch_irq[g])
`endif
    );
  end

endmodule
